lsu_bus: RTL and testbench

LSU_BUS -- requirements
Module: lsu_bus

---
 rtl/lsu_bus.sv | 218 +++++++++++++++++++++
 tb/tb_lsu_bus.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus.sv
// Load/store unit bus adapter: a single outstanding access, lane steering, endianness and exception reporting.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN (limit set by TIMEOUT).
package lsu_bus_pkg;
  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LB   = 4'd1,
    LSU_LH   = 4'd2,
    LSU_LW   = 4'd3,
    LSU_LBU  = 4'd4,
    LSU_LHU  = 4'd5,
    LSU_SB   = 4'd6,
    LSU_SH   = 4'd7,
    LSU_SW   = 4'd8
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;
endpackage

// Handshake: a request transfers on a rising edge where req_valid=1 and req_ready=1;
// rsp_valid is a one-cycle pulse with no back-pressure; dbus_req stays high until dbus_ack or dbus_err.
module lsu_bus
  import lsu_bus_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  lsu_op_t           lsu_op,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              endianness,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err,
  output logic [1:0]        rsp_cause,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [XLEN-1:0]   dbus_addr,
  output logic [XLEN-1:0]   dbus_wr_data,
  output logic [XLEN/8-1:0] dbus_wr_strobe,
  input  logic              dbus_ack,
  input  logic              dbus_err,
  input  logic [XLEN-1:0]   dbus_rd_data,
  output lsu_state_t        state_dbg
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lsu_state_t      state, state_nx;
  lsu_op_t         op_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic            endian_q;
  logic [XLEN-1:0] rsp_data_nx;
  logic            rsp_err_nx;
  logic [1:0]      rsp_cause_nx;
  logic [OW+2:0]   sh;
  logic [XLEN-1:0] datum, ld;
  logic [NB-1:0]   strb_base;
  logic [7:0]      b;
  logic [15:0]     h;
  logic [31:0]     w;
  logic            expired;

  function automatic logic is_mem(input lsu_op_t op);
    return (op >= LSU_LB) && (op <= LSU_SW);
  endfunction

  function automatic logic is_store(input lsu_op_t op);
    return op inside {LSU_SB, LSU_SH, LSU_SW};
  endfunction

  function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (op)
      LSU_LH, LSU_LHU, LSU_SH: m = a[0];
      LSU_LW, LSU_SW:          m = (a != 2'b00);
      default:                 m = 1'b0;
    endcase
    return m;
  endfunction

  assign sh             = {addr_q[OW-1:0], 3'b000};
  assign req_ready      = (state == ST_IDLE);
  assign rsp_valid      = (state == ST_RESP);
  assign dbus_req       = (state == ST_BUS);
  assign dbus_we        = dbus_req && is_store(op_q);
  assign dbus_addr      = {addr_q[XLEN-1:OW], {OW{1'b0}}};
  assign dbus_wr_data   = datum << sh;
  assign dbus_wr_strobe = dbus_req ? (strb_base << addr_q[OW-1:0]) : '0;
  assign state_dbg      = state;

  // Store datum: optional byte swap within the access size, before lane steering.
  always_comb begin
    datum     = '0;
    strb_base = '0;
    case (op_q)
      LSU_SB: begin
        datum[7:0] = wdata_q[7:0];
        strb_base  = NB'(1);
      end
      LSU_SH: begin
        datum[15:0] = endian_q ? {wdata_q[7:0], wdata_q[15:8]} : wdata_q[15:0];
        strb_base   = NB'(3);
      end
      LSU_SW: begin
        datum[31:0] = endian_q ? {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]}
                               : wdata_q[31:0];
        strb_base   = NB'(15);
      end
      default: ;
    endcase
  end

  always_comb begin
    b = 8'(dbus_rd_data >> sh);
    h = 16'(dbus_rd_data >> sh);
    w = 32'(dbus_rd_data >> sh);
    if (endian_q) begin
      h = {h[7:0], h[15:8]};
      w = {w[7:0], w[15:8], w[23:16], w[31:24]};
    end
    ld = '0;
    case (op_q)
      LSU_LB:  begin ld = {XLEN{b[7]}};  ld[7:0]  = b; end
      LSU_LBU: ld[7:0] = b;
      LSU_LH:  begin ld = {XLEN{h[15]}}; ld[15:0] = h; end
      LSU_LHU: ld[15:0] = h;
      LSU_LW:  begin ld = {XLEN{w[31]}}; ld[31:0] = w; end
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  // Counts completed BUS cycles; expiry fires on the TIMEOUT-th one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tcnt <= '0;
    else if (state == ST_BUS)  tcnt <= tcnt + 1'b1;
    else                       tcnt <= '0;
  end
  assign expired = (tcnt == TW'(TIMEOUT - 1));
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    rsp_data_nx  = '0;
    rsp_err_nx   = 1'b0;
    rsp_cause_nx = 2'd0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!is_mem(lsu_op)) begin
            state_nx = ST_RESP;
          end else if (is_misaligned(lsu_op, addr[1:0])) begin
            state_nx     = ST_RESP;
            rsp_err_nx   = 1'b1;
            rsp_cause_nx = 2'd1;
          end else begin
            state_nx = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // Bus outcomes take priority over the watchdog in its expiry cycle.
        if (dbus_err) begin
          state_nx     = ST_RESP;
          rsp_err_nx   = 1'b1;
          rsp_cause_nx = 2'd2;
        end else if (dbus_ack) begin
          state_nx    = ST_RESP;
          rsp_data_nx = is_store(op_q) ? '0 : ld;
        end else if (expired) begin
          state_nx     = ST_RESP;
          rsp_err_nx   = 1'b1;
          rsp_cause_nx = 2'd3;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= LSU_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      endian_q  <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_cause <= 2'd0;
    end else begin
      state     <= state_nx;
      rsp_data  <= rsp_data_nx;
      rsp_err   <= rsp_err_nx;
      rsp_cause <= rsp_cause_nx;
      if (state == ST_IDLE && req_valid) begin
        op_q     <= lsu_op;
        addr_q   <= addr;
        wdata_q  <= wr_data;
        endian_q <= endianness;
      end
    end
  end
endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: byte-level reference model, expected-response queue and per-cycle bus checks.
module tb_lsu_bus;
  import lsu_bus_pkg::*;

  localparam int XLEN = 32;
  localparam int TO   = 15;
  localparam int W    = XLEN + 3;

  logic              clk, rst_n, req_valid, req_ready, endianness;
  lsu_op_t           lsu_op;
  logic [XLEN-1:0]   addr, wr_data, rsp_data, dbus_addr, dbus_wr_data, dbus_rd_data;
  logic              rsp_valid, rsp_err, dbus_req, dbus_we, dbus_ack, dbus_err;
  logic [1:0]        rsp_cause;
  logic [XLEN/8-1:0] dbus_wr_strobe;
  lsu_state_t        state_dbg;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cmp_e;
  logic         exp_bus_active = 1'b0;
  logic         exp_we = 1'b0;
  logic [31:0]  exp_addr = '0;
  logic [31:0]  exp_wdata = '0;
  logic [3:0]   exp_strb = '0;

  lsu_bus #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .lsu_op(lsu_op), .addr(addr), .wr_data(wr_data), .endianness(endianness),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_cause(rsp_cause),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wr_data(dbus_wr_data), .dbus_wr_strobe(dbus_wr_strobe),
    .dbus_ack(dbus_ack), .dbus_err(dbus_err), .dbus_rd_data(dbus_rd_data),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: works byte by byte from the access size and lane offset.
  function automatic void model(input lsu_op_t op, input logic [31:0] a, input logic [31:0] wd,
                                input logic en, input logic [31:0] rd,
                                output bit mem, output bit mis, output bit st,
                                output logic [3:0] strb, output logic [31:0] bwd,
                                output logic [31:0] ld);
    int n, off, idx;
    bit sgn;
    n = 0; sgn = 0; st = 0; mem = 1;
    case (op)
      LSU_LB:  begin n = 1; sgn = 1; end
      LSU_LBU: n = 1;
      LSU_LH:  begin n = 2; sgn = 1; end
      LSU_LHU: n = 2;
      LSU_LW:  n = 4;
      LSU_SB:  begin n = 1; st = 1; end
      LSU_SH:  begin n = 2; st = 1; end
      LSU_SW:  begin n = 4; st = 1; end
      default: mem = 0;
    endcase
    off  = int'(a[1:0]);
    mis  = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    strb = '0; bwd = '0; ld = '0;
    if (mem && !mis) begin
      for (int i = 0; i < n; i++) begin
        idx = en ? (n - 1 - i) : i;
        if (st) strb[off + i] = 1'b1;
        bwd[(off + i) * 8 +: 8] = wd[idx * 8 +: 8];
        ld[idx * 8 +: 8]        = rd[(off + i) * 8 +: 8];
      end
      if (sgn && ld[n * 8 - 1])
        for (int j = n * 8; j < 32; j++) ld[j] = 1'b1;
    end
  endfunction

  // Compare process: bus fields whenever a request is out, responses against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dbus_req) begin
        req_cnt++;
        chk("dbus_req_expected", dbus_req, exp_bus_active);
        chk("dbus_addr", dbus_addr, exp_addr);
        chk("dbus_wr_strobe", dbus_wr_strobe, exp_strb);
        chk("dbus_we", dbus_we, exp_we);
        if (exp_we) chk("dbus_wr_data", dbus_wr_data, exp_wdata);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("rsp_data", rsp_data, cmp_e[W-1:3]);
          chk("rsp_err", rsp_err, cmp_e[2]);
          chk("rsp_cause", rsp_cause, cmp_e[1:0]);
        end
      end
    end
  end

  // Driver. kind: 0=ack, 1=err, 2=ack+err together, 3=no answer (watchdog).
  task automatic run_op(input lsu_op_t op, input logic [31:0] a, input logic [31:0] wd,
                        input logic en, input int wait_n, input int kind,
                        input logic [31:0] rd, input bit poke);
    bit mem, mis, st, bus, got;
    logic [3:0]  strb;
    logic [31:0] bwd, ld, e_data;
    logic        e_err;
    logic [1:0]  e_cause;
    int lat, exp_reqs, acc, limit;
    model(op, a, wd, en, rd, mem, mis, st, strb, bwd, ld);
    bus = mem && !mis;
    e_data = '0; e_err = 1'b0; e_cause = 2'd0;
    if (!mem) begin
    end else if (mis) begin
      e_err = 1'b1; e_cause = 2'd1;
    end else if (kind == 1 || kind == 2) begin
      e_err = 1'b1; e_cause = 2'd2;
    end else if (kind == 3) begin
      e_err = 1'b1; e_cause = 2'd3;
    end else begin
      e_data = st ? 32'h0 : ld;
    end
    lat      = !bus ? 1 : (kind == 3 ? 1 + TO : 2 + wait_n);
    exp_reqs = !bus ? 0 : (kind == 3 ? TO : wait_n + 1);
    limit    = lat + 10;
    exp_q.push_back({e_data, e_err, e_cause});
    exp_addr = {a[31:2], 2'b00}; exp_strb = strb; exp_we = st; exp_wdata = bwd;

    @(negedge clk);
    exp_bus_active = bus;
    req_cnt = 0;
    req_valid = 1'b1; lsu_op = op; addr = a; wr_data = wd; endianness = en;
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0; lsu_op = LSU_NONE; addr = $urandom; wr_data = $urandom; endianness = ~en;
    if (bus && kind != 3) begin
      for (int k = 0; k < wait_n; k++) begin
        if (poke) begin
          req_valid = 1'b1; lsu_op = LSU_SB; addr = 32'hDEAD_BEE1; wr_data = 32'h5A5A_5A5A;
        end
        @(negedge clk);
      end
      req_valid = 1'b0;
      dbus_ack = (kind != 1); dbus_err = (kind != 0); dbus_rd_data = rd;
      @(negedge clk);
      dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rd_data = $urandom;
    end
    got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      if (rsp_valid) got = 1;
      else @(negedge clk);
    end
    chk("rsp_seen", got, 1'b1);
    if (got) chk("latency", cyc - acc, lat);
    chk("dbus_req_cycles", req_cnt, exp_reqs);
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 1'b0);
    chk("ready_after", req_ready, 1'b1);
    exp_bus_active = 1'b0;
  endtask

  initial begin : stim
    bit mem, mis, st;
    logic [3:0]  strb;
    logic [31:0] bwd, ld;
    int hold;
    rst_n = 1'b0; req_valid = 1'b0; lsu_op = LSU_NONE; addr = '0; wr_data = '0;
    endianness = 1'b0; dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rd_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_low_dbus_req", dbus_req, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_rsp_cause", rsp_cause, 2'd0);
    chk("reset_dbus_req", dbus_req, 1'b0);
    chk("reset_dbus_we", dbus_we, 1'b0);
    chk("reset_dbus_addr", dbus_addr, 32'h0);
    chk("reset_dbus_wr_data", dbus_wr_data, 32'h0);
    chk("reset_dbus_strobe", dbus_wr_strobe, 4'h0);
    chk("reset_state", state_dbg, ST_IDLE);

    // Pin the model with hand-computed values
    model(LSU_SB, 32'h1003, 32'hAB, 1'b0, 32'h0, mem, mis, st, strb, bwd, ld);
    chk("pin_sb_strobe", strb, 4'h8);
    chk("pin_sb_data", bwd, 32'hAB00_0000);
    model(LSU_LH, 32'h2002, 32'h0, 1'b1, 32'h8012_0000, mem, mis, st, strb, bwd, ld);
    chk("pin_lh_be", ld, 32'h0000_1280);
    model(LSU_LHU, 32'h2002, 32'h0, 1'b0, 32'h8012_0000, mem, mis, st, strb, bwd, ld);
    chk("pin_lhu_le", ld, 32'h0000_8012);
    model(LSU_LB, 32'h5001, 32'h0, 1'b0, 32'h0000_F000, mem, mis, st, strb, bwd, ld);
    chk("pin_lb_sext", ld, 32'hFFFF_FFF0);
    model(LSU_LW, 32'h3001, 32'h0, 1'b0, 32'h0, mem, mis, st, strb, bwd, ld);
    chk("pin_lw_mis", mis, 1'b1);

    run_op(LSU_SB,  32'h1003, 32'h0000_00AB, 1'b0, 0, 0, 32'h0, 0);
    run_op(LSU_LH,  32'h2002, 32'h0,         1'b1, 0, 0, 32'h8012_0000, 0);
    run_op(LSU_LHU, 32'h2002, 32'h0,         1'b0, 0, 0, 32'h8012_0000, 0);
    run_op(LSU_LW,  32'h3001, 32'h0,         1'b0, 0, 0, 32'h0, 0);
    run_op(LSU_LW,  32'h3000, 32'h0,         1'b0, 0, 2, 32'hFFFF_FFFF, 0);
    run_op(LSU_LW,  32'h3004, 32'h0,         1'b0, 1, 1, 32'h1234_5678, 0);
    run_op(lsu_op_t'(4'd12), 32'h7000, 32'h0, 1'b0, 0, 0, 32'h0, 0);
    run_op(LSU_NONE, 32'h7001, 32'h0,        1'b0, 0, 0, 32'h0, 0);
    run_op(LSU_SW,  32'h4000, 32'h1122_3344, 1'b1, 2, 0, 32'h0, 0);
    run_op(LSU_SH,  32'h4002, 32'h0000_BEEF, 1'b0, 1, 0, 32'h0, 0);
    run_op(LSU_SH,  32'h4002, 32'h0000_BEEF, 1'b1, 0, 0, 32'h0, 0);
    run_op(LSU_SH,  32'h4001, 32'h0000_BEEF, 1'b0, 0, 0, 32'h0, 0);
    run_op(LSU_LB,  32'h5001, 32'h0,         1'b0, 0, 0, 32'h0000_F000, 0);
    run_op(LSU_LBU, 32'h5001, 32'h0,         1'b0, 0, 0, 32'h0000_F000, 0);
    run_op(LSU_LW,  32'h6000, 32'h0,         1'b1, 0, 0, 32'h1234_5678, 0);
    run_op(LSU_LW,  32'h6000, 32'h0,         1'b0, 3, 0, 32'h8765_4321, 1);
    run_op(LSU_LH,  32'h6003, 32'h0,         1'b0, 0, 0, 32'h0, 0);
    run_op(LSU_LW,  32'h6008, 32'h0,         1'b0, TO - 1, 0, 32'h0BAD_F00D, 0);
`ifdef LSU_TIMEOUT_EN
    run_op(LSU_LW,  32'h6010, 32'h0,         1'b0, 0, 3, 32'h0, 0);
    hold = 5;
`else
    hold = 100;
`endif

    // Stalled transfer, then asynchronous reset in the middle of it
    exp_addr = 32'h40; exp_strb = 4'h0; exp_we = 1'b0; exp_wdata = '0;
    @(negedge clk);
    exp_bus_active = 1'b1;
    req_valid = 1'b1; lsu_op = LSU_LW; addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (hold) @(negedge clk);
    chk("stall_dbus_req", dbus_req, 1'b1);
    chk("stall_no_rsp", rsp_valid, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_dbus_req", dbus_req, 1'b0);
    chk("mid_reset_req_ready", req_ready, 1'b1);
    chk("mid_reset_state", state_dbg, ST_IDLE);
    exp_bus_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(LSU_LW, 32'h44, 32'h0, 1'b0, 0, 0, 32'hCAFE_F00D, 0);

    repeat (2) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
